// File: rtl/vector_ram_if.sv
// ============================================================================
// Module   : vector_ram_if
// Purpose  : Lane-parallel request/response port of a vector_ram.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vector_ram_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PARALLELISM = 4,
  parameter int ADDR_WIDTH  = 10
);
  logic                                   valid;
  logic                                   ready;
  logic                                   write;
  logic [PARALLELISM-1:0][ADDR_WIDTH-1:0] addr;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] wdata;
  logic                                   rvalid;
  logic                                   rready;
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, write, addr, wdata, rready,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, write, addr, wdata, rready,
    output ready, rvalid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/vector_ram_reader.sv
// ============================================================================
// Module   : vector_ram_reader
// Purpose  : Streams one whole vector out of a vector_ram as lane-parallel
//            beats, with bounded outstanding reads and last/keep marking.
// Options  : VECTOR_RAM_READER_SWAP_EN adds a FIN state and a swap pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_ram_reader #(
  parameter int LENGTH          = 1024,
  parameter int DATA_WIDTH      = 32,
  parameter int PARALLELISM     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  wire logic                              clk,
  input  wire logic                              rst,
  input  wire logic                              start,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   swap,
  vector_ram_if.master                           ram,
  output logic                                   out_valid,
  input  wire logic                              out_ready,
  output logic [PARALLELISM*DATA_WIDTH-1:0]      out_data,
  output logic [PARALLELISM-1:0]                 out_keep,
  output logic                                   out_last
);

  localparam int BEATS  = (LENGTH + PARALLELISM - 1) / PARALLELISM;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  // Must match the ADDR_WIDTH the connected vector_ram_if is built with.
  localparam int ADDR_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [CNT_W-1:0]                    r_issue_cnt;
  logic [CNT_W-1:0]                    r_resp_cnt;
  logic [OUT_W-1:0]                    r_outstanding;
  logic                                w_active;
  logic                                w_req_hs;
  logic                                w_rsp_hs;
  logic                                w_issue_last;
  logic                                w_resp_last;
  logic                                w_drain_end;
  logic [PARALLELISM-1:0][ADDR_W-1:0]  w_addr;
  logic [PARALLELISM-1:0]              w_keep;

  function automatic logic [31:0] lane_index(input logic [CNT_W-1:0] cnt, input int lane);
    return 32'(cnt) * 32'(PARALLELISM) + 32'(lane);
  endfunction

  assign w_active     = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_req_hs     = ram.valid && ram.ready;
  assign w_rsp_hs     = ram.rvalid && ram.rready;
  assign w_issue_last = (r_issue_cnt == CNT_W'(BEATS - 1));
  assign w_resp_last  = (r_resp_cnt == CNT_W'(BEATS - 1));
  // The second term covers a response that completed in the same cycle as the final request.
  assign w_drain_end  = (w_rsp_hs && w_resp_last) || (r_resp_cnt == CNT_W'(BEATS));

  assign ram.valid  = (r_state == S_ISSUE) && (r_outstanding < OUT_W'(MAX_OUTSTANDING));
  assign ram.write  = 1'b0;
  assign ram.wdata  = '0;
  assign ram.addr   = w_addr;
  assign ram.rready = out_ready && w_active;

  assign out_valid = ram.rvalid && w_active;
  assign out_data  = ram.rdata;
  assign out_keep  = w_keep;
  assign out_last  = out_valid && w_resp_last;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    w_addr = '0;
    w_keep = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      if (lane_index(r_issue_cnt, i) < 32'(LENGTH)) begin
        w_addr[i] = ADDR_W'(lane_index(r_issue_cnt, i));
      end else begin
        w_addr[i] = ADDR_W'(LENGTH - 1);
      end
      w_keep[i] = out_valid && (lane_index(r_resp_cnt, i) < 32'(LENGTH));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    swap        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_req_hs && w_issue_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_end) begin
`ifdef VECTOR_RAM_READER_SWAP_EN
          w_state_nxt = S_FIN;
`else
          w_state_nxt = S_IDLE;
          done        = 1'b1;
`endif
        end
      end
      S_FIN: begin
`ifdef VECTOR_RAM_READER_SWAP_EN
        done = 1'b1;
        swap = 1'b1;
`endif
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters are held at zero while idle so a new vector always starts at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt   <= '0;
      r_resp_cnt    <= '0;
      r_outstanding <= '0;
    end else if (r_state == S_IDLE) begin
      r_issue_cnt   <= '0;
      r_resp_cnt    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_req_hs) begin
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      end
      if (w_rsp_hs) begin
        r_resp_cnt <= r_resp_cnt + CNT_W'(1);
      end
      case ({w_req_hs, w_rsp_hs})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_ram_reader.sv
// ============================================================================
// Module   : tb_vector_ram_reader
// Purpose  : Scoreboard bench for vector_ram_reader against a 1-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_ram_reader;

  localparam int LEN   = 66;
  localparam int DW    = 32;
  localparam int P     = 4;
  localparam int MAXO  = 4;
  localparam int AW    = 7;
  localparam int BEATS = (LEN + P - 1) / P;
`ifdef VECTOR_RAM_READER_SWAP_EN
  localparam int EXP_LAT  = 2;
  localparam int EXP_SWAP = 1;
`else
  localparam int EXP_LAT  = 1;
  localparam int EXP_SWAP = 0;
`endif

  typedef logic [P-1:0][DW-1:0] row_t;
  typedef struct packed {
    row_t         data;
    logic [P-1:0] keep;
    logic         last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy, done, swap;
  logic            out_valid, out_ready, out_last;
  logic [P*DW-1:0] out_data;
  logic [P-1:0]    out_keep;

  vector_ram_if #(.DATA_WIDTH(DW), .PARALLELISM(P), .ADDR_WIDTH(AW)) ram_if ();

  vector_ram_reader #(
    .LENGTH(LEN), .DATA_WIDTH(DW), .PARALLELISM(P), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .swap(swap),
    .ram(ram_if.master), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int    tests = 0, fails = 0, cyc = 0;
  int    req_cnt, done_cnt, swap_cnt, osd, max_osd;
  int    last_req_cyc, done_cyc, first_beat_cyc, last_beat_cyc;
  beat_t exp_q[$];
  beat_t obs_q[$];
  beat_t mon_b;
  row_t  rq[$];
  row_t  ram_row;
  logic  rdy_toggle, rdy_fix, ord_rand, ord_fix;

  always @(posedge clk) cyc++;

  // RAM model: one-cycle read latency, mem[a] = a*3, responses held until rready.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rq.delete();
      ram_if.rvalid <= 1'b0;
      ram_if.rdata  <= '0;
    end else begin
      if (ram_if.rvalid && ram_if.rready) void'(rq.pop_front());
      if (ram_if.valid && ram_if.ready) begin
        for (int i = 0; i < P; i++) ram_row[i] = DW'(32'(ram_if.addr[i]) * 32'd3);
        rq.push_back(ram_row);
      end
      ram_if.rvalid <= (rq.size() > 0);
      ram_if.rdata  <= (rq.size() > 0) ? rq[0] : '0;
    end
  end

  always @(posedge clk) begin
    #1;
    ram_if.ready = rdy_toggle ? ~ram_if.ready : rdy_fix;
    out_ready    = ord_rand ? 1'($urandom_range(0, 1)) : ord_fix;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        mon_b.data = out_data;
        mon_b.keep = out_keep;
        mon_b.last = out_last;
        obs_q.push_back(mon_b);
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
      end
      if (ram_if.valid && ram_if.ready) begin
        req_cnt++;
        last_req_cyc = cyc;
        osd++;
      end
      if (ram_if.rvalid && ram_if.rready) osd--;
      if (osd > max_osd) max_osd = osd;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (swap) swap_cnt++;
    end
  end

  task automatic clear_mon();
    req_cnt = 0; done_cnt = 0; swap_cnt = 0; osd = 0; max_osd = 0;
    last_req_cyc = 0; done_cyc = 0; first_beat_cyc = -1; last_beat_cyc = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic push_expected();
    beat_t b;
    int    idx;
    for (int k = 0; k < BEATS; k++) begin
      for (int i = 0; i < P; i++) begin
        idx       = k * P + i;
        b.data[i] = DW'(((idx < LEN) ? idx : LEN - 1) * 3);
        b.keep[i] = (idx < LEN);
      end
      b.last = (k == BEATS - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    tests++;
    if (done_cnt == 0) begin
      fails++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, limit);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done, swap, ram_if.valid, ram_if.rready, out_valid, out_last, ram_if.write} !== 8'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, expected 00000000",
               {busy, done, swap, ram_if.valid, ram_if.rready, out_valid, out_last, ram_if.write});
    end
    tests++;
    if (out_keep !== 4'b0000) begin
      fails++;
      $display("FAIL reset_keep: got %b, expected 0000", out_keep);
    end
    for (int i = 0; i < P; i++) begin
      tests++;
      if (ram_if.addr[i] !== AW'(i)) begin
        fails++;
        $display("FAIL reset_addr lane %0d: got %0d, expected %0d", i, ram_if.addr[i], i);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_full_rate();
    beat_t e, o;
    clear_mon();
    push_expected();
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    tests++;
    if (ram_if.valid !== 1'b0) begin
      fails++;
      $display("FAIL full_valid_at_start: got %b, expected 0", ram_if.valid);
    end
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    tests++;
    if ({ram_if.valid, busy} !== 2'b11) begin
      fails++;
      $display("FAIL full_first_request: got valid/busy %b, expected 11", {ram_if.valid, busy});
    end
    wait_done("full", 200);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL full_busy_after_done: got %b, expected 0", busy);
    end
    tests++;
    if (req_cnt != BEATS || done_cnt != 1 || swap_cnt != EXP_SWAP) begin
      fails++;
      $display("FAIL full_counts: got req %0d done %0d swap %0d, expected %0d 1 %0d",
               req_cnt, done_cnt, swap_cnt, BEATS, EXP_SWAP);
    end
    tests++;
    if (done_cyc - last_req_cyc != EXP_LAT) begin
      fails++;
      $display("FAIL full_done_latency: got %0d, expected %0d", done_cyc - last_req_cyc, EXP_LAT);
    end
    tests++;
    if (last_beat_cyc - first_beat_cyc != BEATS - 1) begin
      fails++;
      $display("FAIL full_throughput: got span %0d, expected %0d", last_beat_cyc - first_beat_cyc, BEATS - 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL full_beat missing: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL full_beat: got %h, expected %h", o, e);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL full_extra_beats: got %0d, expected 0", obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    clear_mon();
    push_expected();
    ord_fix = 1'b0;
    start_pulse();
    repeat (20) @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_cnt != MAXO || ram_if.valid !== 1'b0 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL bp_stall: got req %0d valid %b beats %0d, expected %0d 0 0",
               req_cnt, ram_if.valid, obs_q.size(), MAXO);
    end
    ord_fix = 1'b1;
    wait_done("bp", 300);
    tests++;
    if (max_osd > MAXO || req_cnt != BEATS || done_cnt != 1) begin
      fails++;
      $display("FAIL bp_counts: got max_osd %0d req %0d done %0d, expected <=%0d %0d 1",
               max_osd, req_cnt, done_cnt, MAXO, BEATS);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL bp_beat missing: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL bp_beat: got %h, expected %h", o, e);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL bp_extra_beats: got %0d, expected 0", obs_q.size());
    end
  endtask

  task automatic test_random_stall();
    beat_t e, o;
    clear_mon();
    push_expected();
    rdy_toggle = 1'b1;
    ord_rand   = 1'b1;
    start_pulse();
    wait_done("random", 2000);
    rdy_toggle = 1'b0;
    ord_rand   = 1'b0;
    tests++;
    if (max_osd > MAXO || req_cnt != BEATS || done_cnt != 1) begin
      fails++;
      $display("FAIL random_counts: got max_osd %0d req %0d done %0d, expected <=%0d %0d 1",
               max_osd, req_cnt, done_cnt, MAXO, BEATS);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL random_beat missing: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL random_beat: got %h, expected %h", o, e);
        end
      end
    end
    tests++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL random_extra_beats: got %0d, expected 0", obs_q.size());
    end
  endtask

  task automatic test_restart_reset();
    beat_t e, o;
    clear_mon();
    push_expected();
    start_pulse();
    repeat (2) @(posedge clk);
    start_pulse();
    wait_done("restart", 200);
    tests++;
    if (req_cnt != BEATS || done_cnt != 1) begin
      fails++;
      $display("FAIL restart_ignored: got req %0d done %0d, expected %0d 1", req_cnt, done_cnt, BEATS);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL restart_beat missing: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL restart_beat: got %h, expected %h", o, e);
        end
      end
    end
    clear_mon();
    start_pulse();
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_busy_before: got %b, expected 1", busy);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, done, swap, ram_if.valid, ram_if.rready, out_valid, out_last, out_keep} !== 11'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got %b, expected 00000000000",
               {busy, done, swap, ram_if.valid, ram_if.rready, out_valid, out_last, out_keep});
    end
    tests++;
    if (ram_if.addr[0] !== AW'(0) || ram_if.addr[3] !== AW'(3)) begin
      fails++;
      $display("FAIL midreset_addr: got %0d/%0d, expected 0/3", ram_if.addr[0], ram_if.addr[3]);
    end
    @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    push_expected();
    start_pulse();
    wait_done("after_reset", 200);
    tests++;
    if (req_cnt != BEATS || done_cnt != 1 || swap_cnt != EXP_SWAP) begin
      fails++;
      $display("FAIL after_reset_counts: got req %0d done %0d swap %0d, expected %0d 1 %0d",
               req_cnt, done_cnt, swap_cnt, BEATS, EXP_SWAP);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin
        fails++;
        $display("FAIL after_reset_beat missing: got none, expected %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL after_reset_beat: got %h, expected %h", o, e);
        end
      end
    end
  endtask

  initial begin
    start        = 1'b0;
    rdy_toggle   = 1'b0;
    rdy_fix      = 1'b1;
    ord_rand     = 1'b0;
    ord_fix      = 1'b1;
    ram_if.ready = 1'b1;
    out_ready    = 1'b1;
    clear_mon();
    test_reset();
    test_full_rate();
    test_backpressure();
    test_random_stall();
    test_restart_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
